io_arbiter: RTL and testbench



---
 rtl/io_pkg.sv | 20 ++
 rtl/io_arbiter_rr_arb2.sv | 13 +
 rtl/io_arbiter.sv | 163 ++++++++++++++++
 tb/tb_io_arbiter.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_pkg.sv
// Shared types and constants for the I/O page arbiter.
// The state encoding is kept explicit so it stays stable in waveforms.
package io_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic [23:0] IO_PAGE         = 24'hFFFFFF;
  localparam logic [31:0] GPIO_ADR        = 32'hFFFFFF00;
  localparam int          IO_WAIT_DEFAULT = 2;

  // An address is in-region when its upper 24 bits select the I/O page.
  function automatic logic in_io_page(input logic [31:0] adr, input logic [23:0] page);
    return adr[31:8] == page;
  endfunction

endpackage

// File: rtl/io_arbiter_rr_arb2.sv
// Two-requester round-robin picker.
// When both masters request, the one that was not granted last wins.
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       last_grant_i,
  output logic       grant_o,
  output logic       grant_valid_o
);

  assign grant_valid_o = |req_i;
  assign grant_o       = (&req_i) ? ~last_grant_i : req_i[1];

endmodule

// File: rtl/io_arbiter.sv
// Two-master arbiter and access sequencer for the memory-mapped I/O page.
// Serialises one transaction at a time with a fixed peripheral wait count.
module io_arbiter
  import io_pkg::*;
#(
  parameter int          WIDTH       = 32,
  parameter int          WAIT_CYCLES = IO_WAIT_DEFAULT,
  parameter logic [23:0] IO_PAGE     = io_pkg::IO_PAGE
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             m0_req,
  input  logic             m0_we,
  input  logic [WIDTH-1:0] m0_adr,
  input  logic [WIDTH-1:0] m0_wdata,
  output logic             m0_ack,
  output logic             m0_err,
  output logic [WIDTH-1:0] m0_rdata,
  input  logic             m1_req,
  input  logic             m1_we,
  input  logic [WIDTH-1:0] m1_adr,
  input  logic [WIDTH-1:0] m1_wdata,
  output logic             m1_ack,
  output logic             m1_err,
  output logic [WIDTH-1:0] m1_rdata,
  output logic [WIDTH-1:0] io_adr,
  output logic [WIDTH-1:0] io_wdata,
  output logic             io_we,
  input  logic [WIDTH-1:0] io_rdata
);

  localparam logic [3:0] CNT_LOAD = 4'(WAIT_CYCLES - 1);

  state_e           state_q, state_d;
  logic             last_grant_q, last_grant_d;
  logic             gnt_q, gnt_d;
  logic             we_q, we_d;
  logic [3:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] io_adr_q, io_adr_d;
  logic [WIDTH-1:0] io_wdata_q, io_wdata_d;
  logic [WIDTH-1:0] m0_rdata_q, m0_rdata_d;
  logic [WIDTH-1:0] m1_rdata_q, m1_rdata_d;
  logic             m0_err_q, m0_err_d;
  logic             m1_err_q, m1_err_d;

  logic             pick;
  logic             pick_valid;
  logic [WIDTH-1:0] sel_adr;
  logic [WIDTH-1:0] sel_wdata;
  logic             sel_we;
  logic [WIDTH-1:0] resp_rdata;

  rr_arb2 u_arb (
    .req_i        ({m1_req, m0_req}),
    .last_grant_i (last_grant_q),
    .grant_o      (pick),
    .grant_valid_o(pick_valid)
  );

  assign sel_adr    = pick ? m1_adr   : m0_adr;
  assign sel_wdata  = pick ? m1_wdata : m0_wdata;
  assign sel_we     = pick ? m1_we    : m0_we;
  assign resp_rdata = we_q ? '0 : io_rdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      gnt_q        <= 1'b0;
      we_q         <= 1'b0;
      cnt_q        <= '0;
      io_adr_q     <= '0;
      io_wdata_q   <= '0;
      m0_rdata_q   <= '0;
      m1_rdata_q   <= '0;
      m0_err_q     <= 1'b0;
      m1_err_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      gnt_q        <= gnt_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      io_adr_q     <= io_adr_d;
      io_wdata_q   <= io_wdata_d;
      m0_rdata_q   <= m0_rdata_d;
      m1_rdata_q   <= m1_rdata_d;
      m0_err_q     <= m0_err_d;
      m1_err_q     <= m1_err_d;
    end
  end

  // Response registers are loaded on entry to RESP so they are valid with ack
  // and then hold until the next ack to the same master.
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    gnt_d        = gnt_q;
    we_d         = we_q;
    cnt_d        = cnt_q;
    io_adr_d     = io_adr_q;
    io_wdata_d   = io_wdata_q;
    m0_rdata_d   = m0_rdata_q;
    m1_rdata_d   = m1_rdata_q;
    m0_err_d     = m0_err_q;
    m1_err_d     = m1_err_q;

    case (state_q)
      IDLE: begin
        if (pick_valid) begin
          gnt_d        = pick;
          last_grant_d = pick;
          we_d         = sel_we;
          if (in_io_page(32'(sel_adr), IO_PAGE)) begin
            state_d    = ACCESS;
            cnt_d      = CNT_LOAD;
            io_adr_d   = sel_adr;
            io_wdata_d = sel_wdata;
          end else begin
            state_d = RESP;
            if (pick) begin
              m1_err_d   = 1'b1;
              m1_rdata_d = '0;
            end else begin
              m0_err_d   = 1'b1;
              m0_rdata_d = '0;
            end
          end
        end
      end

      ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = RESP;
          if (gnt_q) begin
            m1_err_d   = 1'b0;
            m1_rdata_d = resp_rdata;
          end else begin
            m0_err_d   = 1'b0;
            m0_rdata_d = resp_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end

      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign m0_ack   = (state_q == RESP) && !gnt_q;
  assign m1_ack   = (state_q == RESP) &&  gnt_q;
  assign m0_err   = m0_err_q;
  assign m1_err   = m1_err_q;
  assign m0_rdata = m0_rdata_q;
  assign m1_rdata = m1_rdata_q;
  assign io_adr   = io_adr_q;
  assign io_wdata = io_wdata_q;
  // The strobe is decoded from state so an asynchronous reset removes it at once.
  assign io_we    = (state_q == ACCESS) && we_q && (cnt_q == CNT_LOAD);

endmodule

// File: tb/tb_io_arbiter.sv
// Self-checking bench for io_arbiter: table-driven single-master vectors plus
// hand-written contention, reset-abort and single-wait-state sequences.
module tb_io_arbiter;
  import io_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;

  logic        m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_adr = 0, m0_wdata = 0, m1_adr = 0, m1_wdata = 0;
  logic        m0_ack, m0_err, m1_ack, m1_err, io_we;
  logic [31:0] m0_rdata, m1_rdata, io_adr, io_wdata, io_rdata;

  logic        w1_m0_req = 0, w1_m0_we = 0, w1_m1_req = 0, w1_m1_we = 0;
  logic [31:0] w1_m0_adr = 0, w1_m0_wdata = 0, w1_m1_adr = 0, w1_m1_wdata = 0;
  logic        w1_m0_ack, w1_m0_err, w1_m1_ack, w1_m1_err, w1_io_we;
  logic [31:0] w1_m0_rdata, w1_m1_rdata, w1_io_adr, w1_io_wdata;
  logic [31:0] w1_io_rdata = 0;

  logic [31:0] gpio = 0;
  logic [31:0] othRdata = 0;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  io_arbiter #(.WIDTH(32), .WAIT_CYCLES(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_adr(m0_adr), .m0_wdata(m0_wdata),
    .m0_ack(m0_ack), .m0_err(m0_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_we(m1_we), .m1_adr(m1_adr), .m1_wdata(m1_wdata),
    .m1_ack(m1_ack), .m1_err(m1_err), .m1_rdata(m1_rdata),
    .io_adr(io_adr), .io_wdata(io_wdata), .io_we(io_we), .io_rdata(io_rdata)
  );

  io_arbiter #(.WIDTH(32), .WAIT_CYCLES(1)) dut1 (
    .clk(clk), .rst_n(rst_n),
    .m0_req(w1_m0_req), .m0_we(w1_m0_we), .m0_adr(w1_m0_adr), .m0_wdata(w1_m0_wdata),
    .m0_ack(w1_m0_ack), .m0_err(w1_m0_err), .m0_rdata(w1_m0_rdata),
    .m1_req(w1_m1_req), .m1_we(w1_m1_we), .m1_adr(w1_m1_adr), .m1_wdata(w1_m1_wdata),
    .m1_ack(w1_m1_ack), .m1_err(w1_m1_err), .m1_rdata(w1_m1_rdata),
    .io_adr(w1_io_adr), .io_wdata(w1_io_wdata), .io_we(w1_io_we), .io_rdata(w1_io_rdata)
  );

  // Peripheral model: one GPIO register at GPIO_ADR, other addresses return othRdata.
  always @(posedge clk) if (io_we && io_adr == GPIO_ADR) gpio <= io_wdata;
  assign io_rdata = (io_adr == GPIO_ADR) ? gpio : othRdata;

  typedef struct {
    logic        mst;
    logic        we;
    logic [31:0] adr;
    logic [31:0] wdata;
    logic [31:0] oth;
    logic        expErr;
    logic [31:0] expRdata;
    int          expAck;
    int          expWe;
    logic [31:0] expIoAdr;
  } vec_t;

  vec_t vecs[8];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v, output int ackCyc, output logic err,
                               output logic [31:0] rdata, output int otherAcks,
                               output int weCount, output int weCyc,
                               output logic [31:0] weAdr, output logic [31:0] weData);
    ackCyc = -1; err = 1'bx; rdata = 'x; otherAcks = 0;
    weCount = 0; weCyc = -1; weAdr = 'x; weData = 'x;
    @(posedge clk); #1;
    othRdata = v.oth;
    if (v.mst) begin
      m1_req = 1; m1_we = v.we; m1_adr = v.adr; m1_wdata = v.wdata;
    end else begin
      m0_req = 1; m0_we = v.we; m0_adr = v.adr; m0_wdata = v.wdata;
    end
    for (int c = 0; c < 20 && ackCyc < 0; c++) begin
      @(negedge clk);
      if (io_we) begin
        weCount++; weCyc = c; weAdr = io_adr; weData = io_wdata;
      end
      if (v.mst ? m1_ack : m0_ack) begin
        ackCyc = c;
        err    = v.mst ? m1_err : m0_err;
        rdata  = v.mst ? m1_rdata : m0_rdata;
      end
      if (v.mst ? m0_ack : m1_ack) otherAcks++;
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
  endtask

  int          ackCyc, otherAcks, weCount, weCyc, nAck;
  logic        gotErr;
  logic [31:0] gotRdata, weAdr, weData;
  int          ackM[4];
  int          ackC[4];

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    //        mst   we    adr           wdata         oth           err   rdata         ack we ioAdr
    vecs[0] = '{1'b0, 1'b1, 32'hFFFFFF00, 32'h000000A5, 32'h00000000, 1'b0, 32'h00000000, 3, 1, 32'hFFFFFF00};
    vecs[1] = '{1'b1, 1'b0, 32'hFFFFFF04, 32'h00000000, 32'h12345678, 1'b0, 32'h12345678, 3, 0, 32'hFFFFFF04};
    vecs[2] = '{1'b0, 1'b0, 32'hFFFFFF00, 32'h00000000, 32'hDEADBEEF, 1'b0, 32'h000000A5, 3, 0, 32'hFFFFFF00};
    vecs[3] = '{1'b0, 1'b0, 32'h00001000, 32'h00000000, 32'hDEADBEEF, 1'b1, 32'h00000000, 1, 0, 32'hFFFFFF00};
    vecs[4] = '{1'b1, 1'b1, 32'hFFFFFF00, 32'h0000005A, 32'h00000000, 1'b0, 32'h00000000, 3, 1, 32'hFFFFFF00};
    vecs[5] = '{1'b1, 1'b0, 32'hFFFFFF00, 32'h00000000, 32'h00000000, 1'b0, 32'h0000005A, 3, 0, 32'hFFFFFF00};
    vecs[6] = '{1'b1, 1'b1, 32'h12345600, 32'h00000099, 32'h00000000, 1'b1, 32'h00000000, 1, 0, 32'hFFFFFF00};
    vecs[7] = '{1'b0, 1'b0, 32'hFFFFFF20, 32'h00000000, 32'hCAFEF00D, 1'b0, 32'hCAFEF00D, 3, 0, 32'hFFFFFF20};

    repeat (3) @(posedge clk);
    @(negedge clk); rst_n = 1;
    @(negedge clk);
    $display("[TB] reset state");
    checkOutput("rst m0_ack", {31'b0, m0_ack}, 32'h0);
    checkOutput("rst m1_ack", {31'b0, m1_ack}, 32'h0);
    checkOutput("rst m0_err", {31'b0, m0_err}, 32'h0);
    checkOutput("rst m1_rdata", m1_rdata, 32'h0);
    checkOutput("rst io_adr", io_adr, 32'h0);
    checkOutput("rst io_wdata", io_wdata, 32'h0);
    checkOutput("rst io_we", {31'b0, io_we}, 32'h0);

    $display("[TB] single-master vectors");
    for (int i = 0; i < 8; i++) begin
      applyStimulus(vecs[i], ackCyc, gotErr, gotRdata, otherAcks, weCount, weCyc, weAdr, weData);
      checkOutput($sformatf("v%0d ack cycle", i), ackCyc, vecs[i].expAck);
      checkOutput($sformatf("v%0d err", i), {31'b0, gotErr}, {31'b0, vecs[i].expErr});
      checkOutput($sformatf("v%0d rdata", i), gotRdata, vecs[i].expRdata);
      checkOutput($sformatf("v%0d other ack", i), otherAcks, 0);
      checkOutput($sformatf("v%0d io_we pulses", i), weCount, vecs[i].expWe);
      checkOutput($sformatf("v%0d io_adr", i), io_adr, vecs[i].expIoAdr);
      if (vecs[i].expWe == 1) begin
        checkOutput($sformatf("v%0d io_we cycle", i), weCyc, 1);
        checkOutput($sformatf("v%0d io_we adr", i), weAdr, vecs[i].adr);
        checkOutput($sformatf("v%0d io_we data", i), weData, vecs[i].wdata);
      end
    end
    checkOutput("hold m1_err", {31'b0, m1_err}, 32'h1);
    checkOutput("hold m1_rdata", m1_rdata, 32'h0);
    checkOutput("gpio value", gpio, 32'h5A);

    $display("[TB] contention after reset");
    rst_n = 0;
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1;
    for (int k = 0; k < 4; k++) begin ackM[k] = -1; ackC[k] = -1; end
    @(posedge clk); #1;
    othRdata = 32'h11110000;
    m0_req = 1; m0_we = 0; m0_adr = 32'hFFFFFF08;
    m1_req = 1; m1_we = 0; m1_adr = 32'hFFFFFF0C;
    nAck = 0;
    for (int c = 0; c < 40 && nAck < 4; c++) begin
      @(negedge clk);
      if (m0_ack && m1_ack) checkOutput("dual ack", 32'h1, 32'h0);
      if (m0_ack || m1_ack) begin
        ackM[nAck] = m1_ack ? 1 : 0;
        ackC[nAck] = c;
        nAck++;
      end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    for (int k = 0; k < 4; k++) begin
      checkOutput($sformatf("rr grant %0d master", k), ackM[k], k % 2);
      checkOutput($sformatf("rr grant %0d cycle", k), ackC[k], 3 + 4 * k);
    end
    checkOutput("rr m1_rdata", m1_rdata, 32'h11110000);

    $display("[TB] reset during access");
    @(posedge clk); #1;
    m1_req = 1; m1_we = 1; m1_adr = 32'hFFFFFF00; m1_wdata = 32'h77;
    @(negedge clk);
    @(negedge clk);
    checkOutput("abort io_we cycle1", {31'b0, io_we}, 32'h1);
    @(negedge clk);
    checkOutput("abort io_adr before", io_adr, 32'hFFFFFF00);
    #1 rst_n = 0;
    #1;
    checkOutput("abort io_adr", io_adr, 32'h0);
    checkOutput("abort io_wdata", io_wdata, 32'h0);
    checkOutput("abort io_we", {31'b0, io_we}, 32'h0);
    checkOutput("abort m1_ack", {31'b0, m1_ack}, 32'h0);
    checkOutput("abort m1_rdata", m1_rdata, 32'h0);
    m1_req = 0;
    nAck = 0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (m1_ack) nAck++;
    end
    checkOutput("abort no ack", nAck, 0);
    rst_n = 1;
    checkOutput("abort gpio", gpio, 32'h77);
    @(posedge clk); #1;
    m0_req = 1; m0_adr = 32'hFFFFFF08; m1_req = 1; m1_we = 0; m1_adr = 32'hFFFFFF0C;
    ackM[0] = -1; ackC[0] = -1;
    for (int c = 0; c < 20 && ackC[0] < 0; c++) begin
      @(negedge clk);
      if (m0_ack || m1_ack) begin ackM[0] = m1_ack ? 1 : 0; ackC[0] = c; end
    end
    @(posedge clk); #1;
    m0_req = 0; m1_req = 0;
    checkOutput("post-abort first master", ackM[0], 0);
    checkOutput("post-abort first cycle", ackC[0], 3);

    $display("[TB] single wait state back-to-back");
    @(posedge clk); #1;
    w1_m0_req = 1; w1_m0_we = 0; w1_m0_adr = 32'hFFFFFF10;
    w1_io_rdata = 32'hC0DE0000;
    for (int k = 0; k < 4; k++) begin ackM[k] = -1; ackC[k] = -1; end
    nAck = 0;
    for (int c = 0; c < 30 && nAck < 3; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
        w1_io_rdata = 32'hC0DE0000 + 32'(c);
      end
      @(negedge clk);
      if (w1_m1_ack) checkOutput("w1 m1_ack", 32'h1, 32'h0);
      if (w1_m0_ack) begin
        ackC[nAck] = c;
        ackM[nAck] = int'(w1_m0_rdata);
        nAck++;
      end
    end
    @(posedge clk); #1;
    w1_m0_req = 0;
    checkOutput("w1 ack0 cycle", ackC[0], 2);
    checkOutput("w1 ack1 cycle", ackC[1], 5);
    checkOutput("w1 ack2 cycle", ackC[2], 8);
    checkOutput("w1 ack0 rdata", ackM[0], 32'hC0DE0001);
    checkOutput("w1 ack1 rdata", ackM[1], 32'hC0DE0004);
    checkOutput("w1 ack2 rdata", ackM[2], 32'hC0DE0007);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
